sc2bin_seq_array: RTL and testbench
===================================

// Module: sc2bin_seq_array
// PURPOSE
//  Self-sequenced ROW x COL array of stochastic-to-binary converters, and the successor to sc2bin_array.
//  Each cell up/down-counts NPOS positive and NNEG negative SC streams over a programmable window, then
//  rescales by shft_amt, applies optional ReLU, saturates, and streams results out row by row.
//  Sits between the sc_sng_block/MAC fabric and the binary activation buffer.
// PARAMETERS
//  BITWIDTH  8  binary result width; full stream length is 2**BITWIDTH
//  MAX_SHFT  4  largest window shortening; window = 2**(BITWIDTH-shft) cycles
//  ROW       2  array rows
//  COL       2  array columns
//  NPOS      2  positive SC streams per cell
//  NNEG      2  negative SC streams per cell
// PORTS
//  clk       in   1                    clock
//  reset_n   in   1                    asynchronous active-low reset
//  start     in   1                    begin conversion; accepted only in IDLE
//  shft_amt  in   SW=clog2(MAX_SHFT+1) window shortening; sampled with start
//  relu_en   in   1                    1: unsigned ReLU output; 0: signed two's-complement output; sampled with start
//  sc_pos    in   ROW*COL*NPOS         cell c = r*COL+k owns bits [c*NPOS +: NPOS]
//  sc_neg    in   ROW*COL*NNEG         cell c owns bits [c*NNEG +: NNEG]
//  busy      out  1                    high in every state except IDLE
//  out_valid out  1                    a row is presented on bin_out
//  out_ready in   1                    consumer accepts the row
//  out_row   out  clog2(ROW) (min 1)   index of the row on bin_out
//  bin_out   out  COL*BITWIDTH         column k at [k*BITWIDTH +: BITWIDTH]
//  done      out  1                    one-cycle pulse after the last row is accepted
// BEHAVIOUR
//  Reset: state=IDLE; every accumulator, window counter and result register is 0.
//   busy, out_valid, out_row, bin_out and done are all 0.
//  FSM: IDLE -> COUNT -> CONV -> PUSH -> IDLE.
//  IDLE:  on start, latch min(shft_amt, MAX_SHFT) and relu_en.
//   Clear all accumulators and load the window counter with L = 2**(BITWIDTH-shft).
//  COUNT: runs exactly L cycles, starting the cycle after start is accepted.
//   Each cycle, per cell: acc += popcount(pos bits) - popcount(neg bits).
//   acc is signed, ACC_W = BITWIDTH + clog2(max(NPOS,NNEG)) + 2 bits, so it never overflows.
//  CONV: one cycle.
//   val = acc <<< shft.
//   relu_en=1: clamp val to [0, 2**BITWIDTH-1].
//   relu_en=0: clamp val to [-2**(BITWIDTH-1), 2**(BITWIDTH-1)-1].
//   Write val into the per-cell result registers.
//  PUSH: out_row starts at 0; out_valid=1.
//   bin_out holds the result registers of row out_row.
//   A transfer happens when out_valid & out_ready.
//   While out_ready=0, bin_out and out_row are held stable.
//   After a transfer on row ROW-1: out_valid drops, done pulses for one cycle, and the FSM returns to IDLE.
//  Latency: first out_valid is asserted L+2 cycles after the start edge.
//   With out_ready tied high, done pulses L+2+ROW cycles after start.
//  start outside IDLE is ignored; latched config cannot change mid-run.
//   start in the same cycle as done's IDLE entry is accepted on the next edge.
//  SC inputs are ignored outside COUNT.
//  Reset asserted mid-operation: immediate return to IDLE with reset values; partial results are discarded.
//  Result registers persist until the next start clears them.
// TESTING (BITWIDTH=8, ROW=2, COL=2, NPOS=NNEG=2)
//  1. shft=0, relu=1; cell0 pos bit0=1 every cycle, neg bit0=1 on alternate cycles, other cells idle
//     -> 256 COUNT cycles; cell0 result 128, others 0; out_valid rises 258 cycles after start.
//  2. shft=3, relu=1; cell3 pos bit1 high for 20 of the 32 window cycles
//     -> cell3 result 160; row1 shows {160,0}.
//  3. cell1 net count -100 at shft=0: relu=1 -> 0; relu=0 -> 8'h9C.
//     Both pos bits high all window at shft=0 -> 255 with relu=1, 127 with relu=0.
//  4. out_ready low 5 cycles during row0 -> out_valid, out_row=0 and bin_out stable.
//     Then 2 transfers, done pulses once, busy falls the same cycle.
//  5. start re-pulsed mid-COUNT -> ignored, window length unchanged.
//     reset_n low mid-COUNT -> busy=0, out_valid=0 at once; a new start gives a correct fresh result.
//  6. shft_amt=7 with MAX_SHFT=4 -> clamped to 4; window is 16 cycles.

Source files
------------

// File: rtl/sc2bin_seq_array_if.sv
// rtl/sc2bin_seq_array_if.sv - row output stream interface for sc2bin_seq_array
// One transfer carries one array row of COL binary results.
//   out_valid  master->slave  a row is presented on bin_out
//   out_ready  slave->master  consumer accepts the row
//   out_row    master->slave  index of the row on bin_out
//   bin_out    master->slave  column k at [k*BITWIDTH +: BITWIDTH]
interface sc2bin_seq_array_if #(
    parameter int ROW      = 2,
    parameter int COL      = 2,
    parameter int BITWIDTH = 8
);
    localparam int RW = (ROW > 1) ? $clog2(ROW) : 1;

    logic                    out_valid;
    logic                    out_ready;
    logic [RW-1:0]           out_row;
    logic [COL*BITWIDTH-1:0] bin_out;

    modport master (output out_valid, output out_row, output bin_out, input out_ready);
    modport slave  (input out_valid, input out_row, input bin_out, output out_ready);
endinterface

// File: rtl/sc2bin_seq_array.sv
// rtl/sc2bin_seq_array.sv - self-sequenced ROW x COL stochastic-to-binary converter array
// Each cell up/down-counts its positive and negative SC streams over a window of
// 2**(BITWIDTH-shft) cycles, rescales by shft, clamps (ReLU or signed) and the
// results are streamed out one row per transfer.
//   clk       clock
//   reset_n   asynchronous active-low reset
//   start     begin conversion (accepted only while idle)
//   shft_amt  window shortening, sampled with start, clamped to MAX_SHFT
//   relu_en   1: unsigned ReLU result, 0: signed result; sampled with start
//   sc_pos    cell c owns bits [c*NPOS +: NPOS]
//   sc_neg    cell c owns bits [c*NNEG +: NNEG]
//   busy      high whenever not idle
//   done      one-cycle pulse after the last row is accepted
//   out_if    row stream (out_valid/out_ready/out_row/bin_out)
module sc2bin_seq_array #(
    parameter int BITWIDTH = 8,
    parameter int MAX_SHFT = 4,
    parameter int ROW      = 2,
    parameter int COL      = 2,
    parameter int NPOS     = 2,
    parameter int NNEG     = 2,
    localparam int SW      = $clog2(MAX_SHFT + 1)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [SW-1:0]            shft_amt,
    input  logic                     relu_en,
    input  logic [ROW*COL*NPOS-1:0]  sc_pos,
    input  logic [ROW*COL*NNEG-1:0]  sc_neg,
    output logic                     busy,
    output logic                     done,
    sc2bin_seq_array_if.master       out_if
);
    localparam int NCELL = ROW * COL;
    localparam int RW    = (ROW > 1) ? $clog2(ROW) : 1;
    localparam int NMAX  = (NPOS > NNEG) ? NPOS : NNEG;
    localparam int ACC_W = BITWIDTH + $clog2(NMAX) + 2;
    localparam int VAL_W = ACC_W + MAX_SHFT;
    localparam int CNT_W = BITWIDTH + 1;

    localparam logic [CNT_W-1:0]        FULL_LEN = {1'b1, {BITWIDTH{1'b0}}};
    localparam logic signed [VAL_W-1:0] V_UMAX   = VAL_W'((2 ** BITWIDTH) - 1);
    localparam logic signed [VAL_W-1:0] V_SMAX   = VAL_W'((2 ** (BITWIDTH - 1)) - 1);
    localparam logic signed [VAL_W-1:0] V_SMIN   = VAL_W'(-(2 ** (BITWIDTH - 1)));

    typedef enum logic [1:0] {IDLE, COUNT, CONV, PUSH} state_t;

    state_t                     state;
    logic [SW-1:0]              shft_q;
    logic                       relu_q;
    logic [CNT_W-1:0]           win_cnt;
    logic signed [ACC_W-1:0]    acc   [NCELL];
    logic signed [ACC_W-1:0]    delta [NCELL];
    logic [BITWIDTH-1:0]        res   [NCELL];
    logic [SW-1:0]              shft_clamp;
    logic [RW-1:0]              row_sel;
    logic [COL*BITWIDTH-1:0]    row_data;

    assign shft_clamp = (shft_amt > SW'(MAX_SHFT)) ? SW'(MAX_SHFT) : shft_amt;

    // Per-cycle net count of each cell: popcount(pos) - popcount(neg).
    always_comb begin
        for (int c = 0; c < NCELL; c++) begin
            delta[c] = '0;
            for (int i = 0; i < NPOS; i++)
                delta[c] = delta[c] + ACC_W'(sc_pos[c*NPOS + i]);
            for (int i = 0; i < NNEG; i++)
                delta[c] = delta[c] - ACC_W'(sc_neg[c*NNEG + i]);
        end
    end

    // Row that bin_out is loaded with on the next PUSH update: row 0 on the
    // first presentation, the following row after each accepted transfer.
    always_comb begin
        row_sel  = out_if.out_valid ? out_if.out_row + RW'(1) : '0;
        row_data = '0;
        for (int k = 0; k < COL; k++)
            if (int'(row_sel) < ROW)
                row_data[k*BITWIDTH +: BITWIDTH] = res[int'(row_sel)*COL + k];
    end

    // Rescale a window count to full-length units, then saturate.
    function automatic logic [BITWIDTH-1:0] convert(input logic signed [ACC_W-1:0] a,
                                                    input logic [SW-1:0] sh,
                                                    input logic relu);
        logic signed [VAL_W-1:0] v;
        logic [BITWIDTH-1:0]     r;
        v = {{MAX_SHFT{a[ACC_W-1]}}, a};
        v = v <<< sh;
        r = v[BITWIDTH-1:0];
        if (relu) begin
            if (v[VAL_W-1])
                r = '0;
            else if (v > V_UMAX)
                r = '1;
        end else begin
            if (v > V_SMAX)
                r = {1'b0, {(BITWIDTH-1){1'b1}}};
            else if (v < V_SMIN)
                r = {1'b1, {(BITWIDTH-1){1'b0}}};
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            shft_q           <= '0;
            relu_q           <= 1'b0;
            win_cnt          <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            out_if.out_valid <= 1'b0;
            out_if.out_row   <= '0;
            out_if.bin_out   <= '0;
            for (int c = 0; c < NCELL; c++) begin
                acc[c] <= '0;
                res[c] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shft_q  <= shft_clamp;
                        relu_q  <= relu_en;
                        win_cnt <= FULL_LEN >> shft_clamp;
                        busy    <= 1'b1;
                        state   <= COUNT;
                        for (int c = 0; c < NCELL; c++) begin
                            acc[c] <= '0;
                            res[c] <= '0;
                        end
                    end
                end
                COUNT: begin
                    for (int c = 0; c < NCELL; c++)
                        acc[c] <= acc[c] + delta[c];
                    win_cnt <= win_cnt - CNT_W'(1);
                    if (win_cnt == CNT_W'(1))
                        state <= CONV;
                end
                CONV: begin
                    for (int c = 0; c < NCELL; c++)
                        res[c] <= convert(acc[c], shft_q, relu_q);
                    state <= PUSH;
                end
                PUSH: begin
                    // First PUSH cycle registers row 0 onto bin_out.
                    if (!out_if.out_valid) begin
                        out_if.out_valid <= 1'b1;
                        out_if.out_row   <= '0;
                        out_if.bin_out   <= row_data;
                    end else if (out_if.out_ready) begin
                        if (out_if.out_row == RW'(ROW - 1)) begin
                            out_if.out_valid <= 1'b0;
                            done             <= 1'b1;
                            busy             <= 1'b0;
                            state            <= IDLE;
                        end else begin
                            out_if.out_row <= out_if.out_row + RW'(1);
                            out_if.bin_out <= row_data;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sc2bin_seq_array.sv
// tb/tb_sc2bin_seq_array.sv - randomized self-checking bench for sc2bin_seq_array
module tb_sc2bin_seq_array;
    localparam int BITWIDTH = 8;
    localparam int MAX_SHFT = 4;
    localparam int ROW      = 2;
    localparam int COL      = 2;
    localparam int NPOS     = 2;
    localparam int NNEG     = 2;
    localparam int NCELL    = ROW * COL;
    localparam int SW       = $clog2(MAX_SHFT + 1);
    localparam int PW       = NCELL * NPOS;
    localparam int NW       = NCELL * NNEG;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [SW-1:0] shft_amt = '0;
    logic          relu_en = 1'b0;
    logic [PW-1:0] sc_pos = '0;
    logic [NW-1:0] sc_neg = '0;
    logic          busy;
    logic          done;

    sc2bin_seq_array_if #(.ROW(ROW), .COL(COL), .BITWIDTH(BITWIDTH)) out_if ();

    sc2bin_seq_array #(
        .BITWIDTH(BITWIDTH), .MAX_SHFT(MAX_SHFT), .ROW(ROW), .COL(COL),
        .NPOS(NPOS), .NNEG(NNEG)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .shft_amt (shft_amt),
        .relu_en  (relu_en),
        .sc_pos   (sc_pos),
        .sc_neg   (sc_neg),
        .busy     (busy),
        .done     (done),
        .out_if   (out_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [PW-1:0] pos_pat [256];
    logic [NW-1:0] neg_pat [256];
    int            exp_val [NCELL];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: net count over the window, scaled to full length, then saturated.
    task automatic model(input int sh, input bit relu);
        int s, len, net, v, lo, hi;
        s   = (sh > MAX_SHFT) ? MAX_SHFT : sh;
        len = 2 ** (BITWIDTH - s);
        lo  = relu ? 0 : -(2 ** (BITWIDTH - 1));
        hi  = relu ? (2 ** BITWIDTH) - 1 : (2 ** (BITWIDTH - 1)) - 1;
        for (int c = 0; c < NCELL; c++) begin
            net = 0;
            for (int j = 0; j < len; j++)
                net += $countones(pos_pat[j][c*NPOS +: NPOS]) - $countones(neg_pat[j][c*NNEG +: NNEG]);
            v = net * (2 ** s);
            if (v < lo) v = lo;
            if (v > hi) v = hi;
            exp_val[c] = v;
        end
    endtask

    task automatic clear_pats();
        for (int j = 0; j < 256; j++) begin
            pos_pat[j] = '0;
            neg_pat[j] = '0;
        end
    endtask

    task automatic fill_random();
        int pb [NCELL];
        int nb [NCELL];
        for (int c = 0; c < NCELL; c++) begin
            pb[c] = int'($urandom_range(0, 8));
            nb[c] = int'($urandom_range(0, 8));
        end
        for (int j = 0; j < 256; j++)
            for (int c = 0; c < NCELL; c++) begin
                for (int i = 0; i < NPOS; i++)
                    pos_pat[j][c*NPOS + i] = (int'($urandom_range(0, 7)) < pb[c]);
                for (int i = 0; i < NNEG; i++)
                    neg_pat[j][c*NNEG + i] = (int'($urandom_range(0, 7)) < nb[c]);
            end
    endtask

    // Called at a negedge; start is presented immediately so back-to-back runs
    // also exercise a start arriving right as the previous done pulses.
    task automatic run(input int sh, input bit relu, input int stall_row,
                       input int stall_len, input bit restart);
        int s, len, n;
        bit seen;
        logic [COL*BITWIDTH-1:0] row_exp;
        s   = (sh > MAX_SHFT) ? MAX_SHFT : sh;
        len = 2 ** (BITWIDTH - s);
        model(sh, relu);
        shft_amt = SW'(sh);
        relu_en  = relu;
        start    = 1'b1;
        sc_pos   = PW'($urandom);
        sc_neg   = NW'($urandom);
        @(negedge clk);
        start    = 1'b0;
        shft_amt = SW'($urandom);
        relu_en  = 1'($urandom);
        sc_pos   = pos_pat[0];
        sc_neg   = neg_pat[0];
        check("done_clear", 64'(done), 64'(0));
        n = 0;
        seen = 1'b0;
        while (!seen && n < len + 10) begin
            @(negedge clk);
            n++;
            if (n < len) begin
                sc_pos = pos_pat[n];
                sc_neg = neg_pat[n];
            end else begin
                sc_pos = PW'($urandom);
                sc_neg = NW'($urandom);
            end
            if (restart && n == 5) begin
                start = 1'b1;
                shft_amt = SW'(0);
            end
            if (restart && n == 6) start = 1'b0;
            if (n == 1) check("busy_run", 64'(busy), 64'(1));
            if (out_if.out_valid) seen = 1'b1;
        end
        check("valid_latency", 64'(n), 64'(len + 2));
        if (!seen) return;
        for (int r = 0; r < ROW; r++) begin
            for (int k = 0; k < COL; k++)
                row_exp[k*BITWIDTH +: BITWIDTH] = BITWIDTH'(exp_val[r*COL + k]);
            check("row_valid", 64'(out_if.out_valid), 64'(1));
            check("row_idx", 64'(out_if.out_row), 64'(r));
            check("row_data", 64'(out_if.bin_out), 64'(row_exp));
            if (r == stall_row) begin
                out_if.out_ready = 1'b0;
                for (int i = 0; i < stall_len; i++) begin
                    @(negedge clk);
                    n++;
                    check("stall_valid", 64'(out_if.out_valid), 64'(1));
                    check("stall_row", 64'(out_if.out_row), 64'(r));
                    check("stall_data", 64'(out_if.bin_out), 64'(row_exp));
                end
                out_if.out_ready = 1'b1;
            end
            @(negedge clk);
            n++;
        end
        check("done_pulse", 64'(done), 64'(1));
        check("busy_end", 64'(busy), 64'(0));
        check("valid_end", 64'(out_if.out_valid), 64'(0));
        if (stall_row >= ROW || stall_len == 0)
            check("done_latency", 64'(n), 64'(len + 2 + ROW));
    endtask

    task automatic abort_run(input bit in_push);
        int n;
        fill_random();
        shft_amt = SW'(MAX_SHFT);
        relu_en  = 1'b1;
        sc_pos   = PW'($urandom);
        sc_neg   = NW'($urandom);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        if (in_push) begin
            out_if.out_ready = 1'b0;
            while (!out_if.out_valid && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("abort_reach_push", 64'(out_if.out_valid), 64'(1));
        end else begin
            repeat (5) @(negedge clk);
            check("abort_busy_before", 64'(busy), 64'(1));
        end
        reset_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_valid", 64'(out_if.out_valid), 64'(0));
        check("abort_row", 64'(out_if.out_row), 64'(0));
        check("abort_data", 64'(out_if.bin_out), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        out_if.out_ready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        out_if.out_ready = 1'b1;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_valid", 64'(out_if.out_valid), 64'(0));
        check("rst_row", 64'(out_if.out_row), 64'(0));
        check("rst_data", 64'(out_if.bin_out), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        reset_n = 1'b1;
        @(negedge clk);

        // Full window, cell0 +1 every cycle and -1 every other cycle.
        clear_pats();
        for (int j = 0; j < 256; j++) begin
            pos_pat[j][0] = 1'b1;
            neg_pat[j][0] = (j % 2 == 0);
        end
        run(0, 1'b1, ROW, 0, 1'b0);

        // 32-cycle window, cell3 pos bit1 high for 20 cycles.
        clear_pats();
        for (int j = 0; j < 20; j++) pos_pat[j][3*NPOS + 1] = 1'b1;
        run(3, 1'b1, ROW, 0, 1'b0);

        // Negative net count in cell1 under both output modes.
        clear_pats();
        for (int j = 0; j < 100; j++) neg_pat[j][1*NNEG] = 1'b1;
        run(0, 1'b1, ROW, 0, 1'b0);
        run(0, 1'b0, ROW, 0, 1'b0);

        // Positive saturation in cell1.
        clear_pats();
        for (int j = 0; j < 256; j++) pos_pat[j][1*NPOS +: NPOS] = '1;
        run(0, 1'b1, ROW, 0, 1'b0);
        run(0, 1'b0, ROW, 0, 1'b0);

        // Backpressure on row 0.
        fill_random();
        run(2, 1'b0, 0, 5, 1'b0);

        // start re-pulsed during COUNT.
        fill_random();
        run(2, 1'b1, ROW, 0, 1'b1);

        // Reset mid-COUNT and mid-PUSH, each followed by a fresh run.
        abort_run(1'b0);
        fill_random();
        run(4, 1'b0, ROW, 0, 1'b0);
        abort_run(1'b1);
        fill_random();
        run(1, 1'b1, ROW, 0, 1'b0);

        // Out-of-range shift clamps to MAX_SHFT.
        fill_random();
        run(7, 1'b1, ROW, 0, 1'b0);

        for (int t = 0; t < 8; t++) begin
            fill_random();
            run(int'($urandom_range(0, 7)), 1'($urandom),
                int'($urandom_range(0, ROW)), int'($urandom_range(0, 3)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
